sprite_line_renderer: RTL and testbench
=======================================

// Module: sprite_line_renderer
// PURPOSE
//  Scanline sprite engine downstream of the sprite pattern ROM. Holds a sprite attribute table, and for
//  each requested scanline fetches one 32-pixel ROM row per visible sprite, composites it into a
//  double-buffered line buffer, and serves the finished line to the VGA pixel path one line later.
// PARAMETERS
//  N_SPRITES  16   attribute table entries (index width IW = clog2(N_SPRITES))
//  SPRITE_W   32   pixels per ROM row; must equal ROM pattern width
//  SPRITE_H   32   rows per sprite
//  H_ACTIVE   640  visible pixels per line; line buffer depth
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  attr_we      in   1        write attribute entry
//  attr_addr    in   IW       entry index
//  attr_data    in   32       {5'b0, en[26], id[25:20], y[19:10], x[9:0]}
//  start        in   1        1-cycle pulse: swap buffers, render render_line into back buffer
//  render_line  in   10       scanline to render, sampled on start
//  busy         out  1        rendering in progress
//  done         out  1        1-cycle pulse when last entry processed
//  rom_sprite   out  6        to ROM n_sprite
//  rom_line     out  10       to ROM line (row within sprite)
//  rom_pattern  in   32x24    ROM pattern, valid 1 cycle after rom_sprite/rom_line
//  pix_rd       in   1        scanout read strobe
//  pix_x        in   10       scanout column, 0..H_ACTIVE-1
//  pix_rgb      out  24       front-buffer colour, registered
//  pix_valid    out  1        1 = sprite pixel present (else background shows)
// BEHAVIOUR
//  Reset: busy=0, done=0, rom_sprite=0, rom_line=0, pix_rgb=0, pix_valid=0, front select=0, FSM IDLE,
//   attribute table cleared (all en=0), both per-pixel valid bitmaps (2 x H_ACTIVE flops) cleared.
//  Colour storage is RAM, not reset; pix_valid gates it.
//  Attribute write takes effect next cycle; render reads table combinationally from registers.
//  Pattern column c (0=leftmost) = rom_pattern[SPRITE_W-1-c]; 24'h000000 is transparent.
//  FSM: IDLE -> (start) CHECK. CHECK entry i: row = render_line - y as 11-bit signed;
//   if en && 0<=row<SPRITE_H: drive rom_sprite=id, rom_line=row[9:0] -> WAIT (1 cycle) -> LATCH
//   pattern -> WRITE; else i++ (1 cycle). WRITE: c=0..SPRITE_W-1 one per cycle; write colour and set
//   valid at x+c if pixel nonzero and x+c < H_ACTIVE (11-bit sum; clip, never wrap). After entry
//   N_SPRITES-1: done=1 for one cycle, busy=0, IDLE.
//  Priority: entries processed ascending; later nonzero pixel overwrites earlier.
//  Worst case N_SPRITES*(SPRITE_W+3) cycles (560 default) < 800-cycle line.
//  start: front/back swap in same cycle; back buffer is the previously displayed line, already
//   cleared by scanout. start while busy: abort current line (no done), swap, restart at entry 0.
//  Scanout: on pix_rd, next cycle pix_rgb/pix_valid = front[pix_x]; front valid bit at pix_x
//   cleared same edge (clear-on-read). pix_rd=0: outputs hold. pix_x >= H_ACTIVE: pix_valid=0, no clear.
//  Render writes only back buffer; scanout touches only front; no port conflict.
// TESTING
//  1 Reset mid-render (busy=1) -> all outputs 0 next cycle; pix_rd sweep 0..639 gives pix_valid=0.
//  2 Entry0 {en,id=1,y=50,x=100}, start line 50 -> rom_sprite=1, rom_line=0; after done, start;
//    pix_x=112 -> 24'h2d2d06 valid; pix_x=111 -> pix_valid=0; reread 112 -> pix_valid=0 (cleared).
//  3 Clip: id=1,y=50,x=630, line 60 -> x=639 = 24'hbbc868; x=0..21 pix_valid=0 (no wrap).
//  4 Priority: entry2 id1 x=100, entry5 id1 x=101, y=50, line 63 -> x=109 = 24'h99980a (entry5).
//  5 Miss/disabled: y=50 line 82, other entries en=0 -> no ROM row latched, done 16 cycles after start.
//  6 start while busy at entry 3 -> one done only, 560 cycles max after second start; line 2 content.

Source files
------------

// File: rtl/sprite_line_renderer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sprite_line_renderer - per-scanline sprite compositor feeding a double-buffered
// 24-bit line buffer with clear-on-read scanout.          Rev 1.0
// ----------------------------------------------------------------------------
module sprite_line_renderer #(
    parameter int N_SPRITES = 16,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32,
    parameter int H_ACTIVE  = 640,
    localparam int IW = $clog2(N_SPRITES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    attr_we,
    input  logic [IW-1:0]           attr_addr,
    input  logic [31:0]             attr_data,
    input  logic                    start,
    input  logic [9:0]              render_line,
    output logic                    busy,
    output logic                    done,
    output logic [5:0]              rom_sprite,
    output logic [9:0]              rom_line,
    input  logic [SPRITE_W*24-1:0]  rom_pattern,
    input  logic                    pix_rd,
    input  logic [9:0]              pix_x,
    output logic [23:0]             pix_rgb,
    output logic                    pix_valid
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int XW = $clog2(H_ACTIVE);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_LATCH, S_WRITE} state_t;

    logic [26:0]              r_attr [N_SPRITES];
    state_t                   r_state;
    logic [IW-1:0]            r_idx;
    logic [9:0]               r_line;
    logic [9:0]               r_x;
    logic [CW-1:0]            r_col;
    logic [SPRITE_W*24-1:0]   r_pat;
    logic                     r_front;
    logic [23:0]              r_mem0 [H_ACTIVE];
    logic [23:0]              r_mem1 [H_ACTIVE];
    logic [H_ACTIVE-1:0]      r_valid0;
    logic [H_ACTIVE-1:0]      r_valid1;

    logic [26:0]   w_cur;
    logic [10:0]   w_row;
    logic          w_hit;
    logic          w_last;
    logic [CW-1:0] w_pcol;
    logic [23:0]   w_px;
    logic [10:0]   w_sum;
    logic          w_wr;
    logic [XW-1:0] w_wa;
    logic [XW-1:0] w_ra;
    logic          w_px_in;
    logic          w_unused;

    assign w_cur   = r_attr[r_idx];
    // Signed 11-bit difference: bit 10 set means the sprite starts below this line.
    assign w_row   = {1'b0, r_line} - {1'b0, w_cur[19:10]};
    assign w_hit   = w_cur[26] && !w_row[10] && (w_row < 11'(SPRITE_H));
    assign w_last  = (r_idx == IW'(N_SPRITES - 1));
    assign w_pcol  = CW'(SPRITE_W - 1) - r_col;
    assign w_px    = r_pat[w_pcol*24 +: 24];
    assign w_sum   = {1'b0, r_x} + 11'(r_col);
    assign w_wr    = (r_state == S_WRITE) && !start && (w_px != 24'h0) && (w_sum < 11'(H_ACTIVE));
    assign w_wa    = w_sum[XW-1:0];
    assign w_ra    = pix_x[XW-1:0];
    assign w_px_in = ({1'b0, pix_x} < 11'(H_ACTIVE));
    assign w_unused = &{1'b0, attr_data[31:27]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPRITES; i++) r_attr[i] <= '0;
        end else if (attr_we) begin
            r_attr[attr_addr] <= attr_data[26:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_line     <= '0;
            r_x        <= '0;
            r_col      <= '0;
            r_pat      <= '0;
            r_front    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rom_sprite <= '0;
            rom_line   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A start mid-render abandons the current line without a done pulse.
                r_front <= ~r_front;
                r_line  <= render_line;
                r_idx   <= '0;
                busy    <= 1'b1;
                r_state <= S_CHECK;
            end else begin
                case (r_state)
                    S_CHECK: begin
                        if (w_hit) begin
                            rom_sprite <= w_cur[25:20];
                            rom_line   <= w_row[9:0];
                            r_x        <= w_cur[9:0];
                            r_state    <= S_WAIT;
                        end else if (w_last) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    S_WAIT:  r_state <= S_LATCH;
                    S_LATCH: begin
                        r_pat   <= rom_pattern;
                        r_col   <= '0;
                        r_state <= S_WRITE;
                    end
                    S_WRITE: begin
                        r_col <= r_col + 1'b1;
                        if (r_col == CW'(SPRITE_W - 1)) begin
                            if (w_last) begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= S_CHECK;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Colour RAM: back buffer is buffer 0 when r_front=1, buffer 1 otherwise.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            if (r_front) r_mem0[w_wa] <= w_px;
            else         r_mem1[w_wa] <= w_px;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid0  <= '0;
            r_valid1  <= '0;
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                if (r_front) r_valid0[w_wa] <= 1'b1;
                else         r_valid1[w_wa] <= 1'b1;
            end
            if (pix_rd) begin
                if (w_px_in) begin
                    pix_rgb   <= r_front ? r_mem1[w_ra] : r_mem0[w_ra];
                    pix_valid <= r_front ? r_valid1[w_ra] : r_valid0[w_ra];
                    if (r_front) r_valid1[w_ra] <= 1'b0;
                    else         r_valid0[w_ra] <= 1'b0;
                end else begin
                    pix_valid <= 1'b0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sprite_line_renderer.sv
`default_nettype none
// Scoreboard bench for sprite_line_renderer driven by a synthetic pattern ROM model.
module tb_sprite_line_renderer;
    localparam int SW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            attr_we;
    logic [3:0]      attr_addr;
    logic [31:0]     attr_data;
    logic            start;
    logic [9:0]      render_line;
    logic            busy;
    logic            done;
    logic [5:0]      rom_sprite;
    logic [9:0]      rom_line;
    logic [SW*24-1:0] rom_pattern;
    logic            pix_rd;
    logic [9:0]      pix_x;
    logic [23:0]     pix_rgb;
    logic            pix_valid;

    typedef struct {
        bit          chk;
        bit          ev;
        logic [23:0] ergb;
        int          x;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   vcount   = 0;
    logic rd_d     = 1'b0;
    int   n;
    int   c;

    always #5 clk = ~clk;

    sprite_line_renderer dut (
        .clk(clk), .rst_n(rst_n),
        .attr_we(attr_we), .attr_addr(attr_addr), .attr_data(attr_data),
        .start(start), .render_line(render_line),
        .busy(busy), .done(done),
        .rom_sprite(rom_sprite), .rom_line(rom_line), .rom_pattern(rom_pattern),
        .pix_rd(pix_rd), .pix_x(pix_x), .pix_rgb(pix_rgb), .pix_valid(pix_valid)
    );

    // Column c of sprite id, row ln: transparent when c%4==3, else {id*16+ln, c*8, c+1}.
    function automatic logic [23:0] rom_px(input logic [5:0] id, input logic [9:0] ln, input int col);
        if (col % 4 == 3) return 24'h0;
        return {8'(id * 16 + ln), 8'(col * 8), 8'(col + 1)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < SW; k++)
            rom_pattern[(SW-1-k)*24 +: 24] <= rom_px(rom_sprite, rom_line, k);
    end

    always @(posedge clk) rd_d <= pix_rd;

    always @(negedge clk) begin
        if (rst_n && rd_d) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: read response with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                if (pix_valid) vcount++;
                if (mon_e.chk) begin
                    n_checks++;
                    if (pix_valid !== mon_e.ev || (mon_e.ev && pix_rgb !== mon_e.ergb)) begin
                        n_errors++;
                        $display("FAIL pix x=%0d: got valid=%b rgb=%h, want valid=%b rgb=%h",
                                 mon_e.x, pix_valid, pix_rgb, mon_e.ev, mon_e.ergb);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    task automatic write_attr(input int addr, input bit en, input int id, input int y, input int x);
        attr_we   = 1'b1;
        attr_addr = 4'(addr);
        attr_data = {5'b0, en, 6'(id), 10'(y), 10'(x)};
        @(posedge clk); #1;
        attr_we   = 1'b0;
    endtask

    task automatic do_start(input int line);
        render_line = 10'(line);
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int ncyc, output int cnt);
        cnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    task automatic read_px(input int x, input bit ck, input bit ev, input logic [23:0] rgb);
        sb_q.push_back('{ck, ev, rgb, x});
        pix_rd = 1'b1;
        pix_x  = 10'(x);
        @(posedge clk); #1;
        pix_rd = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string nm, input int exp_cnt);
        vcount = 0;
        for (int x = 0; x < 640; x++) read_px(x, 1'b0, 1'b0, 24'h0);
        settle();
        chk(nm, vcount, exp_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; attr_we = 1'b0; attr_addr = '0; attr_data = '0;
        start = 1'b0; render_line = '0; pix_rd = 1'b0; pix_x = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rom_sprite", rom_sprite, 0);
        chk("reset pix_valid", pix_valid, 0);

        // Row miss: line 82 is 32 rows below y=50
        write_attr(0, 1'b1, 1, 50, 100);
        do_start(82);
        wait_done(100, n);
        chk("miss done latency", n, 16);
        chk("miss rom_sprite", rom_sprite, 0);
        chk("miss busy after done", busy, 0);

        // Single sprite, row 0
        do_start(50);
        wait_done(600, n);
        chk("basic done latency", n, 50);
        chk("basic rom_sprite", rom_sprite, 1);
        chk("basic rom_line", rom_line, 0);
        @(posedge clk); #1;
        chk("done single pulse", done, 0);
        do_start(0);
        wait_done(100, n);
        chk("swap done latency", n, 16);
        read_px(112, 1'b1, 1'b1, 24'h10600d);
        read_px(111, 1'b1, 1'b0, 24'h0);
        read_px(112, 1'b1, 1'b0, 24'h0);
        settle();
        sweep("basic valid count", 23);

        // Right-edge clipping, row 10
        write_attr(0, 1'b1, 1, 50, 630);
        do_start(60);
        wait_done(600, n);
        chk("clip done latency", n, 50);
        chk("clip rom_line", rom_line, 10);
        do_start(0);
        wait_done(100, n);
        read_px(639, 1'b1, 1'b1, 24'h1a480a);
        read_px(700, 1'b1, 1'b0, 24'h0);
        read_px(630, 1'b1, 1'b1, 24'h1a0001);
        settle();
        chk("hold pix_valid", pix_valid, 1);
        chk("hold pix_rgb", pix_rgb, 32'h1a0001);
        read_px(0, 1'b1, 1'b0, 24'h0);
        settle();
        sweep("clip valid count", 6);

        // Priority: entry 5 overlays entry 2, row 13
        write_attr(0, 1'b0, 0, 0, 0);
        write_attr(2, 1'b1, 1, 50, 100);
        write_attr(5, 1'b1, 3, 50, 101);
        do_start(63);
        wait_done(600, n);
        chk("prio done latency", n, 84);
        chk("prio rom_sprite", rom_sprite, 3);
        chk("prio rom_line", rom_line, 13);
        do_start(0);
        wait_done(100, n);
        read_px(109, 1'b1, 1'b1, 24'h3d4009);
        read_px(104, 1'b1, 1'b1, 24'h1d2005);
        read_px(103, 1'b1, 1'b1, 24'h3d1003);
        settle();
        sweep("prio valid count", 29);

        // Restart while busy at entry 3
        do_start(63);
        count_done(37, c);
        chk("abort no early done", c, 0);
        chk("abort busy", busy, 1);
        do_start(50);
        wait_done(600, n);
        chk("restart done latency", n, 84);
        count_done(50, c);
        chk("restart single done", c, 0);
        sweep("aborted line valid count", 24);
        do_start(0);
        wait_done(100, n);
        read_px(109, 1'b1, 1'b1, 24'h304009);
        read_px(104, 1'b1, 1'b1, 24'h102005);
        settle();

        // Asynchronous reset in the middle of a render
        do_start(50);
        repeat (10) @(posedge clk);
        #1;
        chk("pre-reset busy", busy, 1);
        chk("pre-reset rom_sprite", rom_sprite, 1);
        chk("pre-reset pix_valid", pix_valid, 1);
        chk("pre-reset pix_rgb", pix_rgb, 32'h102005);
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset done", done, 0);
        chk("mid reset rom_sprite", rom_sprite, 0);
        chk("mid reset rom_line", rom_line, 0);
        chk("mid reset pix_rgb", pix_rgb, 0);
        chk("mid reset pix_valid", pix_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sweep("post-reset front valid count", 0);
        do_start(50);
        wait_done(100, n);
        chk("post-reset table cleared latency", n, 16);
        chk("post-reset rom_sprite", rom_sprite, 0);
        sweep("post-reset other buffer valid count", 0);

        chk("scoreboard drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
